alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that drives `alu_module` from the initiator side. It accepts one 32-bit ARM-style data-processing instruction per handshake and decodes it. It reads operands from a 16×32 register file, evaluates the condition against stored NZCV flags, drives the ALU's A/B/OP/cmd inputs, then writes back the result and flags. It sits between the instruction source and the combinational ALU.

---
 rtl/alu_ctrl_pkg.sv | 92 +++++++++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types, constants and decode helpers for the ALU issue controller.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // Condition codes (instr[31:28])
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // ALU commands (instr[24:21])
    localparam logic [3:0] CMD_AND = 4'd0;
    localparam logic [3:0] CMD_EOR = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_RSB = 4'd3;
    localparam logic [3:0] CMD_ADD = 4'd4;
    localparam logic [3:0] CMD_TST = 4'd8;
    localparam logic [3:0] CMD_TEQ = 4'd9;
    localparam logic [3:0] CMD_CMP = 4'd10;
    localparam logic [3:0] CMD_CMN = 4'd11;
    localparam logic [3:0] CMD_ORR = 4'd12;
    localparam logic [3:0] CMD_MOV = 4'd13;

    // Flag bit positions inside the {N,Z,C,V} nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Zero-extended 8-bit immediate rotated right by twice the rotate field.
    function automatic logic [31:0] ror_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [63:0] dbl;
        logic [5:0]  amt;
        amt = {1'b0, rot, 1'b0};
        dbl = {24'd0, imm8, 24'd0, imm8};
        dbl = dbl >> amt;
        return dbl[31:0];
    endfunction

    // Evaluate a condition code against the stored flags.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, res;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            COND_NV: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // TST/TEQ/CMP/CMN only update flags, never the destination register.
    function automatic logic is_compare(input logic [3:0] cmd);
        return (cmd[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16x32 register file: two operand read ports, one debug read port, one write port.
module alu_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr_n,
    output logic [31:0] rdata_n,
    input  logic [3:0]  raddr_m,
    output logic [31:0] rdata_m,
    input  logic [3:0]  raddr_d,
    output logic [31:0] rdata_d
);

    logic [31:0] regs_r [NREGS];

    // Register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_n = regs_r[raddr_n];
    assign rdata_m = regs_r[raddr_m];
    assign rdata_d = regs_r[raddr_d];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: decode, condition check, drive ALU, write back.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        done,
    output logic        skipped,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  alu_cmd,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  nzcv,
    input  logic        dbg_we,
    input  logic [3:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata
);

    state_t      state_r, state_nx_s;
    logic [31:0] instr_r;
    logic [31:0] res_r;
    logic [3:0]  flags_r;
    logic [3:0]  nzcv_r;
    logic [31:0] alu_a_r, alu_b_r;
    logic [1:0]  alu_op_r;
    logic [3:0]  alu_cmd_r;

    logic        instr_ready_s, done_s, skipped_s;
    logic        pass_s;
    logic [31:0] rn_data_s, rm_data_s, opb_s;
    logic        rf_we_s;
    logic [3:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;

    // Decoded fields of the latched instruction
    logic [3:0] cond_s, cmd_s, rn_s, rd_s, rm_s;
    logic       imm_s, sbit_s;
    assign cond_s = instr_r[31:28];
    assign imm_s  = instr_r[25];
    assign cmd_s  = instr_r[24:21];
    assign sbit_s = instr_r[20];
    assign rn_s   = instr_r[19:16];
    assign rd_s   = instr_r[15:12];
    assign rm_s   = instr_r[3:0];

    assign pass_s = cond_pass(cond_s, nzcv_r);
    assign opb_s  = imm_s ? ror_imm(instr_r[7:0], instr_r[11:8]) : rm_data_s;

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we_s),
        .waddr   (rf_waddr_s),
        .wdata   (rf_wdata_s),
        .raddr_n (rn_s),
        .rdata_n (rn_data_s),
        .raddr_m (rm_s),
        .rdata_m (rm_data_s),
        .raddr_d (dbg_addr),
        .rdata_d (dbg_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (pass_s) begin
                    state_nx_s = ST_EXEC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nx_s = ST_WB;
            ST_WB:   state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and retire pulses.
    always_comb begin
        instr_ready_s = 1'b0;
        done_s        = 1'b0;
        skipped_s     = 1'b0;
        case (state_r)
            ST_IDLE: instr_ready_s = 1'b1;
            ST_DECODE: begin
                if (pass_s) begin
                    done_s    = 1'b0;
                    skipped_s = 1'b0;
                end else begin
                    done_s    = 1'b1;
                    skipped_s = 1'b1;
                end
            end
            ST_EXEC: done_s = 1'b0;
            ST_WB:   done_s = 1'b1;
            default: done_s = 1'b0;
        endcase
    end

    // Register-file write mux: write-back has priority, debug only while idle.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = 4'd0;
        rf_wdata_s = 32'd0;
        if (state_r == ST_WB && !is_compare(cmd_s)) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = rd_s;
            rf_wdata_s = res_r;
        end else if (state_r == ST_IDLE && dbg_we) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = dbg_addr;
            rf_wdata_s = dbg_wdata;
        end else begin
            rf_we_s    = 1'b0;
        end
    end

    // Datapath registers: instruction latch, ALU drive, result capture, flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r   <= 32'd0;
            alu_a_r   <= 32'd0;
            alu_b_r   <= 32'd0;
            alu_op_r  <= 2'd0;
            alu_cmd_r <= 4'd0;
            res_r     <= 32'd0;
            flags_r   <= 4'd0;
            nzcv_r    <= 4'd0;
        end else begin
            if (state_r == ST_IDLE && instr_valid) begin
                instr_r <= instr;
            end
            if (state_r == ST_DECODE && pass_s) begin
                alu_a_r   <= rn_data_s;
                alu_b_r   <= opb_s;
                alu_op_r  <= instr_r[27:26];
                alu_cmd_r <= cmd_s;
            end
            if (state_r == ST_EXEC) begin
                res_r   <= alu_out;
                flags_r <= alu_flags;
            end
            if (state_r == ST_WB && sbit_s) begin
                nzcv_r <= flags_r;
            end
        end
    end

    assign instr_ready = instr_ready_s;
    assign done        = done_s;
    assign skipped     = skipped_s;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_op      = alu_op_r;
    assign alu_cmd     = alu_cmd_r;
    assign nzcv        = nzcv_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a retire scoreboard.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready, done, skipped;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [1:0]  alu_op;
    logic [3:0]  alu_cmd, alu_flags, nzcv;
    logic        dbg_we;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic        skip;
        logic [3:0]  rd;
        logic [31:0] val;
        logic [3:0]  nz;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NREGS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .done        (done),
        .skipped     (skipped),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cmd     (alu_cmd),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .nzcv        (nzcv),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata)
    );

    // Behavioural stand-in for alu_module (combinational).
    logic [32:0] m_sum;
    logic [31:0] m_res;
    logic        m_c, m_v;
    always_comb begin
        m_sum = 33'd0;
        m_res = 32'd0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (alu_cmd)
            4'd0, 4'd8: m_res = alu_a & alu_b;
            4'd1, 4'd9: m_res = alu_a ^ alu_b;
            4'd2, 4'd10: begin
                m_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (alu_a[31] != alu_b[31]) && (m_res[31] != alu_a[31]);
            end
            4'd3: begin
                m_sum = {1'b0, alu_b} + {1'b0, ~alu_a} + 33'd1;
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (alu_a[31] != alu_b[31]) && (m_res[31] != alu_b[31]);
            end
            4'd4, 4'd11: begin
                m_sum = {1'b0, alu_a} + {1'b0, alu_b};
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (alu_a[31] == alu_b[31]) && (m_res[31] != alu_a[31]);
            end
            4'd12: m_res = alu_a | alu_b;
            4'd13: m_res = alu_b;
            default: m_res = 32'd0;
        endcase
    end
    assign alu_out   = m_res;
    assign alu_flags = {m_res[31], (m_res == 32'd0), m_c, m_v};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input logic [3:0] a, input logic [31:0] d);
        dbg_we    = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
        tick();
        dbg_we    = 1'b0;
    endtask

    task automatic preload();
        dbg_write(4'd1, 32'h0000_0011);
        dbg_write(4'd2, 32'h0000_0101);
    endtask

    task automatic issue(input string tag, input logic [31:0] iw, input logic skip,
                         input logic [3:0] rd, input logic [31:0] val, input logic [3:0] nz);
        exp_t e;
        exp_t g;
        int   lat;
        e.skip = skip; e.rd = rd; e.val = val; e.nz = nz;
        sb.push_back(e);
        chk({tag, "_ready_idle"}, {31'd0, instr_ready}, 32'd1);
        instr       = iw;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 8) begin
            tick();
            lat++;
        end
        g = sb.pop_front();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, lat, g.skip ? 32'd1 : 32'd3);
        chk({tag, "_skipped"}, {31'd0, skipped}, {31'd0, g.skip});
        tick();
        dbg_addr = g.rd;
        #1;
        chk({tag, "_ready_after"}, {31'd0, instr_ready}, 32'd1);
        chk({tag, "_rd"}, dbg_rdata, g.val);
        chk({tag, "_nzcv"}, {28'd0, nzcv}, {28'd0, g.nz});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = 32'd0;
        dbg_we = 1'b0; dbg_addr = 4'd0; dbg_wdata = 32'd0;
        tick(); tick();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_skipped", {31'd0, skipped}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_opcmd", {26'd0, alu_op, alu_cmd}, 32'd0);
        chk("rst_nzcv", {28'd0, nzcv}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        dbg_addr = 4'd3; #1;
        chk("rst_r3", dbg_rdata, 32'd0);

        // ADDS r3 = r1 + r2
        preload();
        issue("adds", 32'hE091_3002, 1'b0, 4'd3, 32'h0000_0112, 4'b0000);
        // SUB r4 = r1 - r2, flags unchanged
        preload();
        issue("sub", 32'hE041_4002, 1'b0, 4'd4, 32'hFFFF_FF10, 4'b0000);
        // CMP r1, r2: no write (r0 stays 0), N set, C clear
        preload();
        issue("cmp", 32'hE151_0002, 1'b0, 4'd0, 32'd0, 4'b1000);
        // ADDEQ with Z=0: skipped
        preload();
        issue("addeq_skip", 32'h0281_50FF, 1'b1, 4'd5, 32'd0, 4'b1000);
        // SUBS r7 = r1 - r1 forces Z=1, C=1
        preload();
        issue("subs_zero", 32'hE051_7001, 1'b0, 4'd7, 32'd0, 4'b0110);
        // ADDEQ now executes: r5 = 0x11 + 0xFF
        preload();
        issue("addeq_exec", 32'h0281_50FF, 1'b0, 4'd5, 32'h0000_0110, 4'b0110);
        // Rotated immediate: 0x3F ror 8
        preload();
        issue("rot_imm", 32'hE281_643F, 1'b0, 4'd6, 32'h3F00_0011, 4'b0110);
        chk("rot_alu_b", alu_b, 32'h3F00_0000);
        chk("rot_alu_a", alu_a, 32'h0000_0011);
        chk("rot_alu_opcmd", {26'd0, alu_op, alu_cmd}, {26'd0, 2'b00, CMD_ADD});

        // Reset during EXEC of ADDS aborts it
        preload();
        instr = 32'hE091_3002;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("abort_exec_nodone", {31'd0, done}, 32'd0);
        chk("abort_exec_notready", {31'd0, instr_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_nodone", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        chk("abort_nodone2", {31'd0, done}, 32'd0);
        dbg_addr = 4'd3; #1;
        chk("abort_r3", dbg_rdata, 32'd0);
        chk("abort_nzcv", {28'd0, nzcv}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
